// File: rtl/serial_adder_nb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : serial_adder_nb_pkg                                        |
// | Purpose : Shared types and helpers for the digit-serial adder.       |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package serial_adder_nb_pkg;

  // Control states of the digit-serial sequencer. Code 2'd3 is unused.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
    return {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
  endfunction

  // Digit counter width; a single-digit operation still needs one bit.
  function automatic int cnt_width(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_adder_nb_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : serial_adder_nb_if                                         |
// | Purpose : start/busy/done operand and result bundle of the adder.    |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface serial_adder_nb_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             SUB;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             V;

  // Controller side: issues requests, observes results.
  modport master (
    output start, SUB, A, B, Cin,
    input  busy, done, S, Cout, V
  );

  // Adder side.
  modport slave (
    input  start, SUB, A, B, Cin,
    output busy, done, S, Cout, V
  );
endinterface
`default_nettype wire

// File: rtl/serial_adder_nb_digit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : adder_digit                                                |
// | Purpose : Combinational DIGIT-bit ripple of full-adder cells.        |
// |           cmsb is the carry into the slice MSB (for overflow).       |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module adder_digit
  import serial_adder_nb_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             cmsb
);
  logic [DIGIT:0] w_c;

  assign w_c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    logic [1:0] w_r;
    assign w_r        = full_add(a[i], b[i], w_c[i]);
    assign s[i]       = w_r[0];
    assign w_c[i+1]   = w_r[1];
  end

  assign co   = w_c[DIGIT];
  assign cmsb = w_c[DIGIT-1];

endmodule
`default_nettype wire

// File: rtl/serial_adder_nb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : serial_adder_nb                                            |
// | Purpose : Multi-cycle adder/subtractor, one DIGIT-bit slice per      |
// |           clock with the carry held in a register. WIDTH must be a   |
// |           multiple of DIGIT and at least 2.                          |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module serial_adder_nb
  import serial_adder_nb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  serial_adder_nb_if.slave  bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             v_q, v_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [DIGIT-1:0] w_slice_s;
  logic             w_co;
  logic             w_cmsb;
  logic [WIDTH-1:0] w_sum_next;
  logic             w_last;

  // Operands are shifted right each RUN cycle, so the active slice is
  // always the low DIGIT bits; this is the cnt*DIGIT slice of the latch.
  adder_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (a_q[DIGIT-1:0]),
    .b    (b_q[DIGIT-1:0]),
    .ci   (carry_q),
    .s    (w_slice_s),
    .co   (w_co),
    .cmsb (w_cmsb)
  );

  // New slice enters at the top of the sum register; after NDIG cycles
  // every slice has landed in its final position.
  assign w_sum_next = WIDTH'({w_slice_s, sum_q} >> DIGIT);
  assign w_last     = (cnt_q == CW'(NDIG - 1));

  // Next-state and datapath decisions for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    s_d     = s_q;
    cout_d  = cout_q;
    v_d     = v_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B ^ {WIDTH{bus.SUB}};
          carry_d = bus.SUB ? 1'b1 : bus.Cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        sum_d   = w_sum_next;
        carry_d = w_co;
        if (w_last) begin
          s_d     = w_sum_next;
          cout_d  = w_co;
          v_d     = w_cmsb ^ w_co;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Register everything; reset clears results and aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.S    = s_q;
  assign bus.Cout = cout_q;
  assign bus.V    = v_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_nb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_serial_adder_nb                                         |
// | Purpose : Self-checking bench: six adder instances (8-bit with       |
// |           DIGIT 1/4/8, 4-bit with DIGIT 1/2/4) against an integer    |
// |           signed/unsigned arithmetic reference.                      |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_serial_adder_nb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_adder_nb_if #(.WIDTH(8)) b81 ();
  serial_adder_nb_if #(.WIDTH(8)) b84 ();
  serial_adder_nb_if #(.WIDTH(8)) b88 ();
  serial_adder_nb_if #(.WIDTH(4)) b41 ();
  serial_adder_nb_if #(.WIDTH(4)) b42 ();
  serial_adder_nb_if #(.WIDTH(4)) b44 ();

  serial_adder_nb #(.WIDTH(8), .DIGIT(1)) u_d81 (.clk(clk), .rst(rst), .bus(b81));
  serial_adder_nb #(.WIDTH(8), .DIGIT(4)) u_d84 (.clk(clk), .rst(rst), .bus(b84));
  serial_adder_nb #(.WIDTH(8), .DIGIT(8)) u_d88 (.clk(clk), .rst(rst), .bus(b88));
  serial_adder_nb #(.WIDTH(4), .DIGIT(1)) u_d41 (.clk(clk), .rst(rst), .bus(b41));
  serial_adder_nb #(.WIDTH(4), .DIGIT(2)) u_d42 (.clk(clk), .rst(rst), .bus(b42));
  serial_adder_nb #(.WIDTH(4), .DIGIT(4)) u_d44 (.clk(clk), .rst(rst), .bus(b44));

  int n_cmp = 0;
  int n_mis = 0;
  logic [7:0] prev8 = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for S/Cout, signed for V.
  task automatic ref_calc(input int w, input int a, input int b, input int cin, input int sub,
                          output int s, output int cout, output int v);
    int m, half, t, sa, sb, sr;
    m    = 1 << w;
    half = 1 << (w - 1);
    if (sub != 0) begin
      t    = a - b;
      cout = (a >= b) ? 1 : 0;
    end else begin
      t    = a + b + cin;
      cout = (t >= m) ? 1 : 0;
    end
    s  = ((t % m) + m) % m;
    sa = (a >= half) ? a - m : a;
    sb = (b >= half) ? b - m : b;
    sr = (sub != 0) ? sa - sb : sa + sb + cin;
    v  = (sr < -half || sr > half - 1) ? 1 : 0;
  endtask

  task automatic drive8(input logic st, input logic sub, input logic cin,
                        input logic [7:0] a, input logic [7:0] b);
    b81.start = st; b81.SUB = sub; b81.Cin = cin; b81.A = a; b81.B = b;
    b84.start = st; b84.SUB = sub; b84.Cin = cin; b84.A = a; b84.B = b;
    b88.start = st; b88.SUB = sub; b88.Cin = cin; b88.A = a; b88.B = b;
  endtask

  task automatic drive4(input logic st, input logic sub, input logic cin,
                        input logic [3:0] a, input logic [3:0] b);
    b41.start = st; b41.SUB = sub; b41.Cin = cin; b41.A = a; b41.B = b;
    b42.start = st; b42.SUB = sub; b42.Cin = cin; b42.A = a; b42.B = b;
    b44.start = st; b44.SUB = sub; b44.Cin = cin; b44.A = a; b44.B = b;
  endtask

  // One 8-bit operation on all three 8-bit instances; inputs are scrambled
  // while running to show the latched operands are what count.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
    int es, ec, ev, l1, l4, l8;
    ref_calc(8, int'(a), int'(b), int'(cin), int'(sub), es, ec, ev);
    drive8(1'b1, sub, cin, a, b);
    @(posedge clk); #1;
    check("busy_d81", 32'(b81.busy), 32'd1);
    check("busy_d84", 32'(b84.busy), 32'd1);
    check("busy_d88", 32'(b88.busy), 32'd1);
    l1 = -1; l4 = -1; l8 = -1;
    for (int n = 1; n <= 12; n++) begin
      drive8(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      @(posedge clk); #1;
      if (n == 1) check("s_held_d81", 32'(b81.S), 32'(prev8));
      if (b81.done === 1'b1 && l1 < 0) l1 = n;
      if (b84.done === 1'b1 && l4 < 0) l4 = n;
      if (b88.done === 1'b1 && l8 < 0) l8 = n;
    end
    check("lat_d81", 32'(l1), 32'd8);
    check("lat_d84", 32'(l4), 32'd2);
    check("lat_d88", 32'(l8), 32'd1);
    check("s_d81", 32'(b81.S), 32'(es));
    check("cout_d81", 32'(b81.Cout), 32'(ec));
    check("v_d81", 32'(b81.V), 32'(ev));
    check("s_d84", 32'(b84.S), 32'(es));
    check("cout_d84", 32'(b84.Cout), 32'(ec));
    check("v_d84", 32'(b84.V), 32'(ev));
    check("s_d88", 32'(b88.S), 32'(es));
    check("cout_d88", 32'(b88.Cout), 32'(ec));
    check("v_d88", 32'(b88.V), 32'(ev));
    check("idle_busy_d81", 32'(b81.busy), 32'd0);
    prev8 = 8'(es);
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic cin, input logic sub);
    int es, ec, ev;
    ref_calc(4, int'(a), int'(b), int'(cin), int'(sub), es, ec, ev);
    drive4(1'b1, sub, cin, a, b);
    @(posedge clk); #1;
    drive4(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    repeat (5) @(posedge clk);
    #1;
    check("s_d41", 32'(b41.S), 32'(es));
    check("cout_d41", 32'(b41.Cout), 32'(ec));
    check("v_d41", 32'(b41.V), 32'(ev));
    check("s_d42", 32'(b42.S), 32'(es));
    check("cout_d42", 32'(b42.Cout), 32'(ec));
    check("v_d42", 32'(b42.V), 32'(ev));
    check("s_d44", 32'(b44.S), 32'(es));
    check("cout_d44", 32'(b44.Cout), 32'(ec));
    check("v_d44", 32'(b44.V), 32'(ev));
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t4, t8, c1, c4, c8, nd;

    // Reset state
    rst = 1'b1;
    drive8(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive4(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(b81.busy), 32'd0);
    check("rst_done", 32'(b81.done), 32'd0);
    check("rst_s", 32'(b81.S), 32'd0);
    check("rst_cout", 32'(b81.Cout), 32'd0);
    check("rst_v", 32'(b81.V), 32'd0);
    check("rst_s_d44", 32'(b44.S), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed corner operations
    run8(8'hFF, 8'h01, 1'b0, 1'b0);
    run8(8'h7F, 8'h01, 1'b0, 1'b0);
    run8(8'h05, 8'h07, 1'b0, 1'b1);
    run8(8'h9C, 8'h64, 1'b1, 1'b0);
    run8(8'h80, 8'h80, 1'b1, 1'b0);
    run8(8'h80, 8'h01, 1'b1, 1'b1);
    run8(8'h00, 8'h00, 1'b1, 1'b1);

    // Random operations
    for (int i = 0; i < 40; i++)
      run8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // start held high: accepts must be NDIG+2 edges apart
    t1 = -1; t4 = -1; t8 = -1; c1 = 0; c4 = 0; c8 = 0;
    drive8(1'b1, 1'b0, 1'b0, 8'h12, 8'h34);
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (b81.done === 1'b1) begin
        if (t1 >= 0) check("space_d81", 32'(e - t1), 32'd10);
        check("hold_s_d81", 32'(b81.S), 32'h46);
        t1 = e; c1++;
      end
      if (b84.done === 1'b1) begin
        if (t4 >= 0) check("space_d84", 32'(e - t4), 32'd4);
        t4 = e; c4++;
      end
      if (b88.done === 1'b1) begin
        if (t8 >= 0) check("space_d88", 32'(e - t8), 32'd3);
        t8 = e; c8++;
      end
    end
    check("pulses_d81", 32'(c1), 32'd4);
    check("pulses_d84", 32'(c4), 32'd10);
    check("pulses_d88", 32'(c8), 32'd13);
    drive8(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (12) @(posedge clk);
    #1;
    prev8 = 8'h46;

    // Reset at the 4th RUN edge aborts the operation
    drive8(1'b1, 1'b0, 1'b0, 8'h21, 8'h43);
    @(posedge clk); #1;
    drive8(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 32'(b81.busy), 32'd0);
    check("abort_done", 32'(b81.done), 32'd0);
    check("abort_s", 32'(b81.S), 32'd0);
    nd = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (b81.done === 1'b1) nd++;
    end
    check("abort_no_done", 32'(nd), 32'd0);
    prev8 = 8'h00;
    run8(8'h21, 8'h43, 1'b0, 1'b0);

    // Exhaustive 4-bit sweep over DIGIT = 1/2/4
    for (int sub = 0; sub < 2; sub++)
      for (int cin = 0; cin < 2; cin++)
        for (int a = 0; a < 16; a++)
          for (int b = 0; b < 16; b++)
            run4(4'(a), 4'(b), 1'(cin), 1'(sub));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
